spi_slave: RTL and testbench

Synchronous SPI slave that terminates the SPI bus driven by the SPI master. The slave sits downstream of the master's `spi_clk`/`spi_mosi`/`spi_ss` pins and returns `spi_miso`. It oversamples the bus with the system clock, deserialises MOSI words to a parallel output, and serialises words taken from a parallel TX port. It is the bus-functional partner used to close the loop on master verification, and it is also synthesisable.

---
 rtl/spi_slave.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave for modes 0-3 with a one-word TX holding register.
// Optional macro SPI_SLAVE_FRAME_ERR_EN adds a frame_err strobe for a deselect mid-word.
module spi_slave #(
  parameter int data_width_c  = 8,
  parameter int sync_stages_c = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  input  logic                    spi_ss,
  output logic                    spi_miso,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic [data_width_c-1:0] tx_din,
  input  logic                    tx_din_valid,
  output logic                    tx_req,
  output logic [data_width_c-1:0] dout,
  output logic                    dout_valid,
  output logic                    busy,
  output logic                    tx_underrun
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                    frame_err
`endif
);
  localparam int cnt_w_c = (data_width_c > 1) ? $clog2(data_width_c) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [sync_stages_c-1:0] clk_sync_q, mosi_sync_q, ss_sync_q;
  logic                     clk_dly_q, mosi_dly_q, ss_dly_q;

  state_t                   state_q, state_d;
  logic [cnt_w_c-1:0]       cnt_q, cnt_d;
  logic [data_width_c-1:0]  rx_q, rx_d, tx_q, tx_d, hold_q, hold_d, dout_q, dout_d;
  logic                     hold_full_q, hold_full_d;
  logic                     dout_valid_q, dout_valid_d, underrun_q, underrun_d;
  logic                     cpol_q, cpol_d, cpha_q, cpha_d;
  logic                     frame_err_q, frame_err_d;
  logic                     load;

  logic clk_s, ss_s, clk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      // ss resets low so a select held across reset is not taken as a fresh fall.
      clk_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      clk_dly_q   <= 1'b0;
      mosi_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[sync_stages_c-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[sync_stages_c-2:0], spi_mosi};
      ss_sync_q   <= {ss_sync_q[sync_stages_c-2:0], spi_ss};
      clk_dly_q   <= clk_sync_q[sync_stages_c-1];
      mosi_dly_q  <= mosi_sync_q[sync_stages_c-1];
      ss_dly_q    <= ss_sync_q[sync_stages_c-1];
    end
  end

  assign clk_s       = clk_sync_q[sync_stages_c-1];
  assign ss_s        = ss_sync_q[sync_stages_c-1];
  assign clk_edge    = clk_s ^ clk_dly_q;
  assign lead_edge   = clk_edge && (clk_s != cpol_q);
  assign trail_edge  = clk_edge && (clk_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  assign ss_fall     = ss_dly_q & ~ss_s;
  assign ss_rise     = ~ss_dly_q & ss_s;

  // Holding handshake: tx_din is taken on a cycle where tx_din_valid and tx_req are
  // both high; tx_din_valid is ignored while tx_req is low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    underrun_d   = 1'b0;
    frame_err_d  = 1'b0;
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    load         = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = ACTIVE;
          cpol_d  = cpol;
          cpha_d  = cpha;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d     = IDLE;
          cnt_d       = '0;
          frame_err_d = (cnt_q != '0);
        end else if (sample_edge) begin
          rx_d = (rx_q << 1) | data_width_c'(mosi_dly_q);
          if (cnt_q == cnt_w_c'(data_width_c - 1)) begin
            dout_d       = rx_d;
            dout_valid_d = 1'b1;
            cnt_d        = '0;
            load         = cpha_q;
          end else begin
            cnt_d = cnt_q + cnt_w_c'(1);
          end
        end else if (shift_edge) begin
          // With cpha=1 a zero count means the MSB is already on the wire.
          if (cnt_q != '0) tx_d = tx_q << 1;
          else             load = ~cpha_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tx_din_valid && !hold_full_q) begin
      hold_d      = tx_din;
      hold_full_d = 1'b1;
    end
    if (load) begin
      if (hold_full_q) begin
        tx_d        = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_d       = '0;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      underrun_q   <= underrun_d;
      frame_err_q  <= frame_err_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
    end
  end

  assign busy        = (state_q == ACTIVE);
  assign spi_miso    = (state_q == ACTIVE) ? tx_q[data_width_c-1] : 1'bz;
  assign tx_req      = ~hold_full_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign tx_underrun = underrun_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign frame_err   = frame_err_q;
`else
  logic unused_frame_err;
  assign unused_frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed and randomized SPI exchanges against a word-level model of the slave.
module tb_spi_slave;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk, spi_mosi, spi_ss, cpol, cpha;
  wire        spi_miso;
  logic [7:0] tx_din;
  logic       tx_din_valid;
  logic       tx_req, dout_valid, busy, tx_underrun;
  logic [7:0] dout;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
  int         frame_err_cnt = 0;
`endif

  spi_slave #(.data_width_c(8), .sync_stages_c(2)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_ss(spi_ss),
    .spi_miso(spi_miso), .cpol(cpol), .cpha(cpha), .tx_din(tx_din),
    .tx_din_valid(tx_din_valid), .tx_req(tx_req), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .tx_underrun(tx_underrun)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected summary");
    $fatal(1, "watchdog");
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         underrun_cnt = 0;
  int         exp_underrun = 0;
  logic [7:0] m_tx[4];
  logic [7:0] m_rx[4];
  logic [7:0] exp_miso[4];
  logic [7:0] hold_m = 8'h00;
  bit         hold_full_m = 1'b0;

  // Monitor: collect received words and strobe counts.
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid) got_q.push_back(dout);
      if (tx_underrun) underrun_cnt++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (frame_err) frame_err_cnt++;
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Word-level model of the holding register.
  task automatic model_load(output logic [7:0] w);
    if (hold_full_m) begin
      w = hold_m;
      hold_full_m = 1'b0;
    end else begin
      w = 8'h00;
      exp_underrun++;
    end
  endtask

  task automatic drive_hold(input logic [7:0] v);
    @(negedge clk);
    tx_din = v;
    tx_din_valid = 1'b1;
    @(negedge clk);
    tx_din_valid = 1'b0;
  endtask

  task automatic write_hold(input logic [7:0] v);
    drive_hold(v);
    hold_m = v;
    hold_full_m = 1'b1;
  endtask

  task automatic wait_tx_req();
    int n;
    n = 0;
    @(negedge clk);
    while (tx_req !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("tx_req_wait", tx_req, 1'b1);
  endtask

  // Driver: bus-functional SPI master.
  task automatic spi_xfer(input logic pol, input logic pha, input int nbits,
                          input bit toggle, input bit raise_ss);
    int w, b;
    @(negedge clk);
    cpol = pol;
    cpha = pha;
    spi_clk = pol;
    repeat (8) @(negedge clk);
    spi_ss = 1'b0;
    if (!pha) spi_mosi = m_tx[0][7];
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      w = i / 8;
      b = 7 - (i % 8);
      if (toggle && i == 3) begin
        cpol = ~pol;
        cpha = ~pha;
      end
      if (!pha) begin
        m_rx[w][b] = spi_miso;
        spi_clk = ~pol;
        repeat (HALF) @(negedge clk);
        spi_clk = pol;
        if (i + 1 < nbits) spi_mosi = m_tx[(i + 1) / 8][7 - ((i + 1) % 8)];
        repeat (HALF) @(negedge clk);
      end else begin
        spi_clk = ~pol;
        spi_mosi = m_tx[w][b];
        repeat (HALF) @(negedge clk);
        m_rx[w][b] = spi_miso;
        spi_clk = pol;
        repeat (HALF) @(negedge clk);
      end
    end
    if (raise_ss) spi_ss = 1'b1;
  endtask

  task automatic start_check();
    got_q.delete();
    exp_q.delete();
    underrun_cnt = 0;
    exp_underrun = 0;
  endtask

  task automatic finish_check(input string name, input int nwords);
    check({name, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({name, "_dout"}, got_q.pop_front(), exp_q.pop_front());
    for (int w = 0; w < nwords; w++) check({name, "_miso"}, m_rx[w], exp_miso[w]);
    check({name, "_underrun"}, underrun_cnt, exp_underrun);
  endtask

  task automatic run_full(input string name, input logic pol, input logic pha,
                          input int nwords, input bit toggle);
    logic [7:0] dummy;
    start_check();
    for (int w = 0; w < nwords; w++) begin
      model_load(exp_miso[w]);
      exp_q.push_back(m_tx[w]);
    end
    model_load(dummy);
    spi_xfer(pol, pha, nwords * 8, toggle, 1'b1);
    repeat (8) @(negedge clk);
    finish_check(name, nwords);
  endtask

  initial begin
    logic [7:0] p, r, dummy;
    logic [1:0] mode;
    int         nw;
    rst = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_ss = 1'b1;
    cpol = 1'b0; cpha = 1'b0; tx_din = 8'h00; tx_din_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_req", tx_req, 1'b1);
    check("rst_dout", dout, 8'h00);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_underrun", tx_underrun, 1'b0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("rst_frame_err", frame_err, 1'b0);
`endif
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Mode 0 exchange; a write while tx_req is low must be ignored.
    write_hold(8'h3C);
    check("m0_tx_req_full", tx_req, 1'b0);
    drive_hold(8'hFF);
    m_tx[0] = 8'hA5;
    run_full("mode0", 1'b0, 1'b0, 1, 1'b0);
    check("m0_tx_req_after", tx_req, 1'b1);

    // Mode 3 exchange with cpol/cpha toggled mid-word.
    write_hold(8'h3C);
    m_tx[0] = 8'hA5;
    run_full("mode3", 1'b1, 1'b1, 1, 1'b1);

    // Back-to-back words with the holding register refilled after each load.
    write_hold(8'h3C);
    r = 8'($urandom);
    m_tx[0] = 8'h11;
    m_tx[1] = 8'h22;
    start_check();
    model_load(exp_miso[0]);
    hold_m = 8'h81; hold_full_m = 1'b1;
    model_load(exp_miso[1]);
    hold_m = r; hold_full_m = 1'b1;
    model_load(dummy);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    fork
      spi_xfer(1'b0, 1'b1, 16, 1'b0, 1'b1);
      begin
        wait_tx_req();
        drive_hold(8'h81);
        wait_tx_req();
        drive_hold(r);
      end
    join
    repeat (8) @(negedge clk);
    finish_check("b2b", 2);

    // Underrun: nothing supplied.
    m_tx[0] = 8'($urandom);
    run_full("underrun", 1'b1, 1'b0, 1, 1'b0);

    // Deselect after 5 bits.
    p = 8'($urandom);
    write_hold(p);
    start_check();
    model_load(dummy);
    m_tx[0] = 8'($urandom);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_cnt = 0;
`endif
    spi_xfer(1'b0, 1'b0, 5, 1'b0, 1'b0);
    @(negedge clk);
    spi_ss = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("desel_busy_n1", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("desel_busy_n2", busy, 1'b0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("desel_frame_err", frame_err, 1'b1);
`endif
    repeat (6) @(negedge clk);
    check("desel_no_dout", got_q.size(), 0);
    check("desel_miso_bits", m_rx[0][7:3], p[7:3]);
    check("desel_tx_req", tx_req, 1'b1);
    check("desel_underrun", underrun_cnt, exp_underrun);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("desel_frame_err_cnt", frame_err_cnt, 1);
`endif

    // Reset after 3 bits with ss still low.
    write_hold(8'($urandom));
    m_tx[0] = 8'($urandom);
    spi_xfer(1'b0, 1'b1, 3, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_dout_valid", dout_valid, 1'b0);
    check("mid_rst_tx_req", tx_req, 1'b1);
    check("mid_rst_underrun", tx_underrun, 1'b0);
    rst = 1'b0;
    hold_full_m = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_rst_wait_fall", busy, 1'b0);
    spi_ss = 1'b1;
    repeat (8) @(negedge clk);
    write_hold(8'($urandom));
    m_tx[0] = 8'($urandom);
    run_full("after_rst", 1'b0, 1'b1, 1, 1'b0);

    // Randomized transfers over all modes.
    for (int t = 0; t < 5; t++) begin
      mode = 2'($urandom_range(0, 3));
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) m_tx[w] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) write_hold(8'($urandom));
      run_full("rand", mode[1], mode[0], nw, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
